// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_if
// Purpose  : Bundles the pipeline-side request/response signals and the
//            memory-side bus of the load/store unit controller.
// Modports : slave  - the LSU controller's view (drives busy/done/fault/
//                     rdata and the mem_* request signals).
//            master - the environment's view (pipeline + memory), the
//                     mirror image of slave.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    // pipeline side
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_store, funct3, addr, wdata,
        output busy, done, fault, rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output start, is_store, funct3, addr, wdata,
        input  busy, done, fault, rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Single-outstanding load/store controller. Accepts one RISC-V
//            style access from the pipeline, checks legality/alignment,
//            issues a word-aligned memory request with byte lanes, and
//            returns an aligned, sign/zero-extended load result.
// Ports    : clk  - clock, all state on the rising edge
//            rst  - synchronous active-high reset
//            bus  - lsu_ctrl_if.slave: start/is_store/funct3/addr/wdata in,
//                   busy/done/fault/rdata out, mem_req/mem_we/mem_addr/
//                   mem_be/mem_wdata out, mem_ready/mem_rvalid/mem_rdata in
// Params   : TIMEOUT - max cycles in REQ+WAIT before a fault, 0 = never
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Counter value on the last allowed REQ/WAIT cycle; the transition out
    // of that cycle is the point at which the count reaches TIMEOUT.
    localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT - 32'd1);

    state_t      r_state;
    state_t      w_next;

    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_tcnt;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // ------------------------------------------------------------------
    // Request decode (applies to the live inputs while in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b0;
        if (bus.is_store) begin
            w_illegal = (bus.funct3 != 3'b000) && (bus.funct3 != 3'b001) &&
                        (bus.funct3 != 3'b010);
        end else begin
            w_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        end
    end

    // funct3[1:0] encodes the size for every legal code (00 b, 01 h, 10 w)
    assign w_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                          ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign w_bad        = w_illegal || w_misaligned;

    always_comb begin
        w_be = 4'b1111;
        case (bus.funct3[1:0])
            2'b00:   w_be = 4'b0001 << bus.addr[1:0];
            2'b01:   w_be = 4'b0011 << bus.addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    assign w_wdata_sh = bus.wdata << {bus.addr[1:0], 3'b000};

    assign w_timeout  = (TIMEOUT != 0) && (r_tcnt == c_TO_LAST);

    // ------------------------------------------------------------------
    // Load-data alignment and extension (uses the latched access)
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_off)
            2'd0: w_byte = bus.mem_rdata[7:0];
            2'd1: w_byte = bus.mem_rdata[15:8];
            2'd2: w_byte = bus.mem_rdata[23:16];
            2'd3: w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
    end

    assign w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_ext = bus.mem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                // A same-cycle rvalid is deliberately ignored here; the
                // read data must be presented again while in WAIT.
                if (bus.mem_ready) begin
                    w_next = r_is_store ? S_DONE : S_WAIT;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_tcnt      <= 32'd0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && bus.start) begin
                r_is_store <= bus.is_store;
                r_funct3   <= bus.funct3;
                r_off      <= bus.addr[1:0];
                // Bus-facing registers only move for a request that will
                // actually be issued, so a rejected access leaves them alone.
                if (!w_bad) begin
                    r_mem_addr  <= {bus.addr[31:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata_sh;
                end
            end

            if ((r_state == S_IDLE) && (w_next == S_REQ)) begin
                r_tcnt <= 32'd0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_tcnt <= r_tcnt + 32'd1;
            end

            if ((r_state == S_WAIT) && bus.mem_rvalid) begin
                r_rdata <= w_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.fault     = (r_state == S_ERR);
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_we    = (r_state == S_REQ) && r_is_store;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
